// File: rtl/param_lifo_stack_pkg.sv
// Shared constants and helpers for the parametrised LIFO stack.
package param_lifo_stack_pkg;

  localparam int LIFO_MODE_REJECT = 0;
  localparam int LIFO_MODE_WRAP   = 1;

  // Occupancy needs one extra bit so that a completely full stack (count == DEPTH) fits.
  function automatic int lifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_lifo_stack_if.sv
// Request/response bundle of the LIFO stack: the master drives requests, the stack (slave) drives status.
interface param_lifo_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  import param_lifo_stack_pkg::*;

  localparam int CW = lifo_count_width(DEPTH);

  // push/pop are plain single-cycle requests sampled on every rising edge; there is no
  // backpressure. out_valid is a one-cycle strobe marking data_out as freshly popped.
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             clear_errors;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data_in, clear_errors,
    input  data_out, out_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, clear_errors,
    output data_out, out_valid, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/param_lifo_stack_storage_ram.sv
// Stack storage: one synchronous write port and one asynchronous read port; contents survive reset.
module lifo_storage_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with reject/wrap full handling, occupancy count, sticky error
// flags, defined simultaneous push+pop and a registered pop output with a valid strobe.
module param_lifo_stack
  import param_lifo_stack_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int WRAP_ON_FULL = LIFO_MODE_REJECT
) (
  input  logic                clock,
  input  logic                reset,
  param_lifo_stack_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = lifo_count_width(DEPTH);

  logic [PW-1:0]    top_q, top_d;
  logic [PW-1:0]    bot_q, bot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             is_full;
  logic             is_empty;
  logic [PW-1:0]    top_m1;
  logic [WIDTH-1:0] rd_data;
  logic             we;
  logic [PW-1:0]    waddr;
  logic             ovf_set;
  logic             unf_set;

  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == '0);
  // DEPTH is a power of two, so pointer arithmetic wraps modulo DEPTH for free.
  assign top_m1   = top_q - PW'(1);

  lifo_storage_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.data_in),
    .raddr_i (top_m1),
    .rdata_o (rd_data)
  );

  always_comb begin
    top_d   = top_q;
    bot_d   = bot_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    we      = 1'b0;
    waddr   = top_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    unique case ({bus.push, bus.pop})
      2'b11: begin
        valid_d = 1'b1;
        if (is_empty) begin
          dout_d = bus.data_in;
        end else begin
          // Read of the old top entry happens before the edge writes the replacement.
          dout_d = rd_data;
          we     = 1'b1;
          waddr  = top_m1;
        end
      end
      2'b10: begin
        if (!is_full) begin
          we    = 1'b1;
          top_d = top_q + PW'(1);
          cnt_d = cnt_q + CW'(1);
        end else begin
          ovf_set = 1'b1;
          if (WRAP_ON_FULL == LIFO_MODE_WRAP) begin
            // When full, top equals bottom: this write overwrites the oldest entry.
            we    = 1'b1;
            top_d = top_q + PW'(1);
            bot_d = bot_q + PW'(1);
          end
        end
      end
      2'b01: begin
        if (!is_empty) begin
          dout_d  = rd_data;
          top_d   = top_m1;
          cnt_d   = cnt_q - CW'(1);
          valid_d = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      default: begin
      end
    endcase

    // A new error in the same cycle as clear_errors wins.
    ovf_d = (ovf_q & ~bus.clear_errors) | ovf_set;
    unf_d = (unf_q & ~bus.clear_errors) | unf_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      top_q   <= '0;
      bot_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      bot_q   <= bot_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.count     = cnt_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed bench for param_lifo_stack: a reject-mode and a wrap-mode instance driven in lockstep.
module tb_param_lifo_stack;
  import param_lifo_stack_pkg::*;

  localparam int W = 32;
  localparam int D = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];

  param_lifo_stack_if #(.WIDTH(W), .DEPTH(D)) if_r ();
  param_lifo_stack_if #(.WIDTH(W), .DEPTH(D)) if_w ();

  param_lifo_stack #(.WIDTH(W), .DEPTH(D), .WRAP_ON_FULL(LIFO_MODE_REJECT)) dut_r (
    .clock (clock),
    .reset (reset),
    .bus   (if_r)
  );

  param_lifo_stack #(.WIDTH(W), .DEPTH(D), .WRAP_ON_FULL(LIFO_MODE_WRAP)) dut_w (
    .clock (clock),
    .reset (reset),
    .bus   (if_w)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver: apply one cycle of inputs to both instances, sample 1 ns after the edge.
  task automatic op(input logic p, input logic q, input logic [W-1:0] d,
                    input logic c, input logic r);
    if_r.push = p; if_r.pop = q; if_r.data_in = d; if_r.clear_errors = c;
    if_w.push = p; if_w.pop = q; if_w.data_in = d; if_w.clear_errors = c;
    reset = r;
    @(posedge clock);
    #1;
    if_r.push = 1'b0; if_r.pop = 1'b0; if_r.data_in = '0; if_r.clear_errors = 1'b0;
    if_w.push = 1'b0; if_w.pop = 1'b0; if_w.data_in = '0; if_w.clear_errors = 1'b0;
    reset = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    op(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    op(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: pops on the reject instance must return the front of exp_q.
  task automatic pop_sb(input string tag);
    logic [W-1:0] e;
    pop();
    e = exp_q.pop_front();
    chk(tag, if_r.data_out, e);
    chk({tag, "_valid"}, 32'(if_r.out_valid), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    if_r.push = 1'b0; if_r.pop = 1'b0; if_r.data_in = '0; if_r.clear_errors = 1'b0;
    if_w.push = 1'b0; if_w.pop = 1'b0; if_w.data_in = '0; if_w.clear_errors = 1'b0;
    reset = 1'b1;

    // Reset state
    op(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_count", 32'(if_r.count), 32'd0);
    chk("rst_empty", 32'(if_r.empty), 32'd1);
    chk("rst_full", 32'(if_r.full), 32'd0);
    chk("rst_dout", if_r.data_out, 32'd0);
    chk("rst_valid", 32'(if_r.out_valid), 32'd0);
    chk("rst_ovf", 32'(if_r.overflow), 32'd0);
    chk("rst_unf", 32'(if_r.underflow), 32'd0);

    // 1. Ordering and occupancy
    push(32'd16); push(32'd64); push(32'd32); push(32'd1);
    chk("t1_count", 32'(if_r.count), 32'd4);
    chk("t1_full", 32'(if_r.full), 32'd1);
    chk("t1_ovf", 32'(if_r.overflow), 32'd0);
    exp_q = '{32'd1, 32'd32, 32'd64, 32'd16};
    pop_sb("t1_pop0"); pop_sb("t1_pop1"); pop_sb("t1_pop2"); pop_sb("t1_pop3");
    chk("t1_empty", 32'(if_r.empty), 32'd1);
    chk("t1_count0", 32'(if_r.count), 32'd0);
    idle();
    chk("t1_valid_drop", 32'(if_r.out_valid), 32'd0);
    chk("t1_dout_hold", if_r.data_out, 32'd16);

    // 2. Underflow
    pop();
    chk("t2_unf", 32'(if_r.underflow), 32'd1);
    chk("t2_valid", 32'(if_r.out_valid), 32'd0);
    chk("t2_dout", if_r.data_out, 32'd16);
    op(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t2_clear", 32'(if_r.underflow), 32'd0);
    op(1'b0, 1'b1, '0, 1'b1, 1'b0);
    chk("t2_set_wins", 32'(if_r.underflow), 32'd1);
    op(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t2_clear2", 32'(if_r.underflow), 32'd0);

    // 3. Push into a full stack (reject vs wrap)
    push(32'd16); push(32'd64); push(32'd32); push(32'd1); push(32'd99);
    chk("t3_r_ovf", 32'(if_r.overflow), 32'd1);
    chk("t3_r_count", 32'(if_r.count), 32'd4);
    chk("t3_w_ovf", 32'(if_w.overflow), 32'd1);
    chk("t3_w_count", 32'(if_w.count), 32'd4);
    exp_q = '{32'd1, 32'd32, 32'd64, 32'd16};
    pop_sb("t3_pop0"); chk("t3_w_pop0", if_w.data_out, 32'd99);
    pop_sb("t3_pop1"); chk("t3_w_pop1", if_w.data_out, 32'd1);
    pop_sb("t3_pop2"); chk("t3_w_pop2", if_w.data_out, 32'd32);
    pop_sb("t3_pop3"); chk("t3_w_pop3", if_w.data_out, 32'd64);
    chk("t3_w_empty", 32'(if_w.empty), 32'd1);
    op(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t3_ovf_clr", 32'(if_r.overflow), 32'd0);

    // 4. Wrap mode keeps the newest DEPTH entries
    push(32'd1); push(32'd2); push(32'd3); push(32'd4); push(32'd5);
    chk("t4_w_count", 32'(if_w.count), 32'd4);
    chk("t4_w_ovf", 32'(if_w.overflow), 32'd1);
    chk("t4_w_full", 32'(if_w.full), 32'd1);
    pop(); chk("t4_w_pop0", if_w.data_out, 32'd5); chk("t4_r_pop0", if_r.data_out, 32'd4);
    pop(); chk("t4_w_pop1", if_w.data_out, 32'd4);
    pop(); chk("t4_w_pop2", if_w.data_out, 32'd3);
    pop(); chk("t4_w_pop3", if_w.data_out, 32'd2); chk("t4_r_pop3", if_r.data_out, 32'd1);
    chk("t4_w_empty", 32'(if_w.empty), 32'd1);
    op(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // 5. Simultaneous push and pop
    push(32'd10); push(32'd20);
    op(1'b1, 1'b1, 32'd30, 1'b0, 1'b0);
    chk("t5_dout", if_r.data_out, 32'd20);
    chk("t5_count", 32'(if_r.count), 32'd2);
    chk("t5_valid", 32'(if_r.out_valid), 32'd1);
    chk("t5_ovf", 32'(if_r.overflow), 32'd0);
    pop(); chk("t5_pop_new", if_r.data_out, 32'd30);
    pop(); chk("t5_pop_old", if_r.data_out, 32'd10);
    chk("t5_empty", 32'(if_r.empty), 32'd1);
    op(1'b1, 1'b1, 32'd7, 1'b0, 1'b0);
    chk("t5_pass_dout", if_r.data_out, 32'd7);
    chk("t5_pass_valid", 32'(if_r.out_valid), 32'd1);
    chk("t5_pass_empty", 32'(if_r.empty), 32'd1);
    chk("t5_pass_unf", 32'(if_r.underflow), 32'd0);
    push(32'd1); push(32'd2); push(32'd3); push(32'd4);
    op(1'b1, 1'b1, 32'd9, 1'b0, 1'b0);
    chk("t5_full_dout", if_r.data_out, 32'd4);
    chk("t5_full_count", 32'(if_r.count), 32'd4);
    chk("t5_full_ovf", 32'(if_r.overflow), 32'd0);
    pop(); chk("t5_full_pop", if_r.data_out, 32'd9);

    // 6. Reset mid-operation
    push(32'd5); push(32'd6); push(32'd7);
    chk("t6_pre_ovf", 32'(if_r.overflow), 32'd1);
    op(1'b1, 1'b0, 32'd9, 1'b0, 1'b1);
    chk("t6_count", 32'(if_r.count), 32'd0);
    chk("t6_empty", 32'(if_r.empty), 32'd1);
    chk("t6_valid", 32'(if_r.out_valid), 32'd0);
    chk("t6_ovf", 32'(if_r.overflow), 32'd0);
    chk("t6_unf", 32'(if_r.underflow), 32'd0);
    chk("t6_dout", if_r.data_out, 32'd0);
    chk("t6_w_count", 32'(if_w.count), 32'd0);
    pop();
    chk("t6_unf_after", 32'(if_r.underflow), 32'd1);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_lifo_stack.md
Name: param_lifo_stack

Overview:
- Parametrised LIFO stack; successor to the fixed 32-bit processor stack.
- Used for the call/return-address stack and as general scratch LIFO storage in the RISC datapath.
- Adds over the fixed stack:
  - configurable width and depth;
  - selectable full-handling mode (reject or wrap-overwrite);
  - occupancy count;
  - sticky overflow/underflow error flags;
  - defined simultaneous push+pop;
  - registered pop output with valid strobe.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
WRAP_ON_FULL, 0, 0 = push when full is rejected; 1 = push when full overwrites the oldest entry (circular)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
push  in  1  push request, sampled on rising edge
pop  in  1  pop request, sampled on rising edge
data_in  in  WIDTH  word to push
clear_errors  in  1  clears sticky overflow/underflow
data_out  out  WIDTH  registered popped word
out_valid  out  1  one-cycle strobe: data_out updated by the previous edge's pop
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a push hit a full stack
underflow  out  1  sticky: a pop hit an empty stack

Behaviour:
- Single clock domain, named clock. Reset is synchronous and active-high, named reset.
- Reset state:
  - count=0, top pointer=0, bottom pointer=0;
  - data_out=0, out_valid=0, overflow=0, underflow=0.
  - Storage array is not cleared.
  - Reset overrides every other input in the same cycle, including a mid-sequence push/pop.
- Derived outputs: full and empty decode combinationally from the count register; no extra latency.
- Pointers: top pointer addresses the next free slot and wraps modulo DEPTH; the top entry is at top-1 (mod DEPTH).
- Push only:
  - Not full: store data_in at top, top+1, count+1.
  - Full, WRAP_ON_FULL=0: no state change except overflow<=1.
  - Full, WRAP_ON_FULL=1: store at top (overwrites the oldest entry), top+1, bottom+1, count stays DEPTH, overflow<=1 (data lost).
- Pop only:
  - Not empty: data_out<=entry[top-1], top-1, count-1, out_valid<=1 next cycle.
  - Empty: underflow<=1, data_out holds, out_valid=0.
- Push and pop together:
  - Not empty (full included): data_out<=current top entry, top slot overwritten with data_in, count unchanged, out_valid<=1, no overflow.
  - Empty: pass-through. data_out<=data_in, out_valid<=1, stack stays empty, no underflow.
- Pop latency: the popped word appears on data_out after the edge that samples pop; it is valid while out_valid=1 for that one cycle and held until the next pop.
- Sticky flags:
  - clear_errors clears overflow and underflow.
  - If a new error occurs in the same cycle as clear_errors, set wins.
- Throughput: back-to-back push or pop every cycle, no bubbles.

Decomposition:
- Shared package:
  - localparams for the WRAP_ON_FULL encodings (LIFO_MODE_REJECT=0, LIFO_MODE_WRAP=1);
  - a count-width helper function (clog2(DEPTH)+1).
- One sub-module: lifo_storage_ram.
  - WIDTH x DEPTH array, one synchronous write port, one asynchronous read port.
  - Pointer/count/flag control stays in param_lifo_stack.

Test Plan:
1. Ordering and occupancy (WIDTH=32, DEPTH=4):
   - Reset, then push 16,64,32,1 -> count=4, full=1.
   - Four pops -> data_out 1,32,64,16 on consecutive cycles, out_valid=1 each cycle, then empty=1, count=0.
2. Underflow:
   - Pop on an empty stack -> underflow=1, out_valid=0, data_out unchanged.
   - Assert clear_errors -> underflow=0.
   - clear_errors together with another empty pop -> underflow stays 1.
3. Reject mode (WRAP_ON_FULL=0):
   - Fill with 16,64,32,1, push 99 -> overflow=1, count=4.
   - Four pops -> 1,32,64,16.
4. Wrap mode (WRAP_ON_FULL=1):
   - Push 1,2,3,4,5 -> count=4, overflow=1.
   - Four pops -> 5,4,3,2, then empty=1.
5. Simultaneous push and pop:
   - Stack [10,20], push 30 with pop -> data_out=20, count=2; next pop -> 30.
   - Empty stack, push 7 with pop -> data_out=7, out_valid=1, empty stays 1, underflow=0.
6. Reset mid-operation:
   - After pushes 5,6,7, assert reset with push=1 and data_in=9 -> next cycle count=0, empty=1, out_valid=0, overflow=underflow=0.
   - A following pop flags underflow.
